// File: rtl/rv_decode_queue_pkg.sv
// Shared opcode/funct3 constants and the decoded record for the RV decode queue.
package rv_decode_pkg;

  localparam int unsigned OPC_W = 5;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned F7_W  = 7;

  localparam logic [OPC_W-1:0] OPCODE_LOAD      = 5'b00000;
  localparam logic [OPC_W-1:0] OPCODE_MISC_MEM  = 5'b00011;
  localparam logic [OPC_W-1:0] OPCODE_OP_IMM    = 5'b00100;
  localparam logic [OPC_W-1:0] OPCODE_AUIPC     = 5'b00101;
  localparam logic [OPC_W-1:0] OPCODE_OP_IMM_32 = 5'b00110;
  localparam logic [OPC_W-1:0] OPCODE_STORE     = 5'b01000;
  localparam logic [OPC_W-1:0] OPCODE_OP        = 5'b01100;
  localparam logic [OPC_W-1:0] OPCODE_LUI       = 5'b01101;
  localparam logic [OPC_W-1:0] OPCODE_OP_32     = 5'b01110;
  localparam logic [OPC_W-1:0] OPCODE_BRANCH    = 5'b11000;
  localparam logic [OPC_W-1:0] OPCODE_JALR      = 5'b11001;
  localparam logic [OPC_W-1:0] OPCODE_JAL       = 5'b11011;
  localparam logic [OPC_W-1:0] OPCODE_SYSTEM    = 5'b11100;

  localparam logic [F3_W-1:0] F3_PRIV     = 3'b000;
  localparam logic [F3_W-1:0] F3_CSRRW    = 3'b001;
  localparam logic [F3_W-1:0] F3_CSRRS    = 3'b010;
  localparam logic [F3_W-1:0] F3_CSRRC    = 3'b011;
  localparam logic [F3_W-1:0] F3_SYS_RSVD = 3'b100;
  localparam logic [F3_W-1:0] F3_CSRRWI   = 3'b101;
  localparam logic [F3_W-1:0] F3_CSRRSI   = 3'b110;
  localparam logic [F3_W-1:0] F3_CSRRCI   = 3'b111;

  typedef struct packed {
    logic             sigill;
    logic [OPC_W-1:0] opcode;
    logic [F3_W-1:0]  funct3;
    logic [F7_W-1:0]  funct7;
    logic [REG_W-1:0] funct5;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } decoded_t;

endpackage

// File: rtl/rv_decode_queue_if.sv
// Fetch-side and execute-side handshake bundle; master is the environment, slave is the queue.
interface rv_decode_queue_if #(parameter int unsigned XLEN = 32);
  import rv_decode_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_pc;
  logic             out_sigill;
  logic [OPC_W-1:0] out_opcode;
  logic [F3_W-1:0]  out_funct3;
  logic [F7_W-1:0]  out_funct7;
  logic [REG_W-1:0] out_funct5;
  logic [REG_W-1:0] out_rd;
  logic [REG_W-1:0] out_rs1;
  logic [REG_W-1:0] out_rs2;
  logic [XLEN-1:0]  out_imm;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_sigill, out_opcode, out_funct3,
           out_funct7, out_funct5, out_rd, out_rs1, out_rs2, out_imm
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_sigill, out_opcode, out_funct3,
           out_funct7, out_funct5, out_rd, out_rs1, out_rs2, out_imm
  );
endinterface

// File: rtl/rv_decode_queue_comb.sv
// rv_decode_comb: purely combinational RV32I/RV64I decode of one instruction word.
// RV_DECODE_QUEUE_ZICSR_EN makes the CSR forms of the system opcode legal.
module rv_decode_comb
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     inst,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic is_r, is_i, is_s, is_b, is_u, is_j, is_sys, is_csr, legal;
  logic [31:0] imm32;

  // Classify the word into an instruction format
  always_comb begin
    is_r   = 1'b0;
    is_i   = 1'b0;
    is_s   = 1'b0;
    is_b   = 1'b0;
    is_u   = 1'b0;
    is_j   = 1'b0;
    is_sys = 1'b0;
    is_csr = 1'b0;
    case (inst[6:2])
      OPCODE_OP:        is_r = 1'b1;
      OPCODE_OP_32:     is_r = (XLEN == 64);
      OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_JALR: is_i = 1'b1;
      OPCODE_OP_IMM_32: is_i = (XLEN == 64);
      OPCODE_STORE:     is_s = 1'b1;
      OPCODE_BRANCH:    is_b = 1'b1;
      OPCODE_LUI, OPCODE_AUIPC: is_u = 1'b1;
      OPCODE_JAL:       is_j = 1'b1;
      OPCODE_SYSTEM: begin
        if (inst[14:12] == F3_PRIV) begin
          is_sys = 1'b1;
        end
`ifdef RV_DECODE_QUEUE_ZICSR_EN
        else if (inst[14:12] != F3_SYS_RSVD) begin
          is_csr = 1'b1;
        end
`endif
      end
      default: ;
    endcase
    legal = (inst[1:0] == 2'b11) &
            (is_r | is_i | is_s | is_b | is_u | is_j | is_sys | is_csr);
  end

  // Drive only the fields the format defines; illegal words carry just sigill
  always_comb begin
    dec   = '0;
    imm   = '0;
    imm32 = '0;
    if (legal) begin
      dec.opcode = inst[6:2];
      if (is_r | is_i | is_s | is_b | is_sys | is_csr) dec.funct3 = inst[14:12];
      if (is_r | is_i | is_u | is_j | is_csr)          dec.rd     = inst[11:7];
      if (is_r | is_i | is_s | is_b | is_csr)          dec.rs1    = inst[19:15];
      if (is_r | is_s | is_b)                          dec.rs2    = inst[24:20];
      // funct7/funct5 select among R-type ops and among priv ops (ecall/ebreak/mret)
      if (is_r | is_sys) begin
        dec.funct7 = inst[31:25];
        dec.funct5 = inst[24:20];
      end
      if (is_i) imm32 = {{20{inst[31]}}, inst[31:20]};
      if (is_s) imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      if (is_b) imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      if (is_u) imm32 = {inst[31:12], 12'b0};
      if (is_j) imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      imm = XLEN'($signed(imm32));
      // CSR number is an unsigned address, not an offset
      if (is_csr) imm = XLEN'(inst[31:20]);
    end else begin
      dec.sigill = 1'b1;
    end
  end

endmodule

// File: rtl/rv_decode_queue.sv
// rv_decode_queue: decodes fetched words and buffers the records in a DEPTH-entry circular queue.
// RV_DECODE_QUEUE_ZICSR_EN (optional) enables Zicsr decode in rv_decode_comb.
module rv_decode_queue
  import rv_decode_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input logic clock,
  input logic reset,
  input logic flush,
  rv_decode_queue_if.slave bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  decoded_t        dec_in;
  logic [XLEN-1:0] imm_in;

  decoded_t        dec_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];
  logic [XLEN-1:0] imm_mem [DEPTH];

  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic             push, pop, out_valid_c;
  decoded_t         head_dec;

  rv_decode_comb #(.XLEN(XLEN)) u_decode (
    .inst (bus.in_inst),
    .dec  (dec_in),
    .imm  (imm_in)
  );

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake qualifiers; in_ready deliberately ignores out_ready
  assign bus.in_ready = ~reset & ~flush & (count < CNT_W'(DEPTH));
  assign out_valid_c  = (count != '0);
  assign push         = bus.in_valid & bus.in_ready;
  assign pop          = out_valid_c & bus.out_ready;

  // Pointer and occupancy update; reset and flush both empty the queue
  always_ff @(posedge clock) begin
    if (reset | flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
      if (push & ~pop)      count <= count + CNT_W'(1);
      else if (pop & ~push) count <= count - CNT_W'(1);
    end
  end

  // Entry storage written at the tail on accept
  always_ff @(posedge clock) begin
    if (push) begin
      dec_mem[tail] <= dec_in;
      pc_mem[tail]  <= bus.in_pc;
      imm_mem[tail] <= imm_in;
    end
  end

  assign head_dec = dec_mem[head];

  // Head presentation, forced to zero while the queue is empty
  always_comb begin
    bus.out_valid  = out_valid_c;
    bus.out_pc     = '0;
    bus.out_sigill = 1'b0;
    bus.out_opcode = '0;
    bus.out_funct3 = '0;
    bus.out_funct7 = '0;
    bus.out_funct5 = '0;
    bus.out_rd     = '0;
    bus.out_rs1    = '0;
    bus.out_rs2    = '0;
    bus.out_imm    = '0;
    if (out_valid_c) begin
      bus.out_pc     = pc_mem[head];
      bus.out_sigill = head_dec.sigill;
      bus.out_opcode = head_dec.opcode;
      bus.out_funct3 = head_dec.funct3;
      bus.out_funct7 = head_dec.funct7;
      bus.out_funct5 = head_dec.funct5;
      bus.out_rd     = head_dec.rd;
      bus.out_rs1    = head_dec.rs1;
      bus.out_rs2    = head_dec.rs2;
      bus.out_imm    = imm_mem[head];
    end
  end

endmodule

// File: doc/rv_decode_queue.md
# rv_decode_queue

Registered RV32I/RV64I instruction decoder with a DEPTH-entry output queue. Sits between fetch and execute. Accepts one 32-bit instruction word plus PC per valid/ready handshake and decodes it into register, opcode, function and immediate fields. Decoded records are buffered so fetch can run ahead of execute, and the whole queue can be dropped on a control-flow flush.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- DEPTH, 4, queue entries; any value ≥ 2.
- clock  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  drop all queued entries and any same-cycle input.
- in_valid  in  1  fetch offers an instruction.
- in_ready  out  1  queue can accept.
- in_inst  in  32  raw instruction word.
- in_pc  in  XLEN  instruction address, carried through unchanged.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  execute consumes head.
- out_pc  out  XLEN  PC of the head entry.
- out_sigill  out  1  head instruction is illegal.
- out_opcode  out  5  inst[6:2].
- out_funct3  out  3  inst[14:12].
- out_funct7  out  7  inst[31:25].
- out_funct5  out  5  inst[24:20].
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign- or zero-extended immediate.

## Operation
- inst[1:0] ≠ 11 → sigill.
- Legal opcodes:
  - op (01100): R-type, imm = 0.
  - load (00000), misc-mem (00011), op-imm (00100), jalr (11001): I-type, rs2 = 0, imm = sext(inst[31:20]).
  - store (01000): S-type, rd = 0.
  - branch (11000): B-type, rd = 0, bit 0 of imm = 0.
  - lui (01101), auipc (00101): imm = sext({inst[31:12], 12'b0}), rs1 = rs2 = 0.
  - jal (11011): J-type, rs1 = rs2 = 0.
  - system (11100) with funct3 = 000: rd = rs1 = rs2 = 0, imm = 0.
- XLEN=64 only:
  - op-imm-32 (00110): decoded as I-type.
  - op-32 (01110): decoded as R-type.
  - With XLEN=32 both are sigill.
- All sign extension goes to the full XLEN width.
- Every field a format does not define is driven to 0, never X.
- Sigill entries are still enqueued, with out_sigill=1, out_pc valid, and every other field 0. Execute raises the trap in program order.
- Queue: circular buffer with head/tail pointers modulo DEPTH and a count of 0..DEPTH.
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged.

## Timing
- Reset: count = 0, pointers = 0, out_valid = 0, in_ready = 0.
  - All out_* fields read 0 while out_valid = 0.
  - in_ready rises the first cycle after reset is deasserted.
- in_ready = ~reset & ~flush & (count < DEPTH).
  - in_ready does not depend on out_ready: a full queue does not accept even when it is popped in the same cycle.
- Latency: an instruction accepted at edge N is at the head by cycle N+1 at the earliest; there is no combinational in→out path.
- Throughput: one instruction per cycle sustained when out_ready = 1.
- out_* fields are stable while out_valid = 1 and out_ready = 0.
- Flush: at the next edge count = 0 and pointers = 0. Same-cycle push and pop are ignored. out_valid = 0 the cycle after.
- Reset mid-operation behaves exactly like flush and additionally holds in_ready low while reset is asserted.

## Configuration
- RV_DECODE_QUEUE_ZICSR_EN defined:
  - system funct3 ∈ {001, 010, 011, 101, 110, 111} is legal.
  - rd = inst[11:7], rs1 = inst[19:15] (uimm for the 1xx forms), rs2 = 0.
  - imm = zero-extended inst[31:20] (CSR number).
  - funct3 = 100 remains sigill.
- Macro undefined: every system encoding with funct3 ≠ 000 is sigill.

## Structure
- Package rv_decode_pkg holds:
  - opcode localparams (OPCODE_OP, OPCODE_LOAD, …, OPCODE_OP_32);
  - funct3 constants for system;
  - a packed struct decoded_t for everything except pc and imm, whose widths depend on XLEN.
- Sub-module rv_decode_comb (parameter XLEN) is the purely combinational decode of one word.
- rv_decode_queue instantiates rv_decode_comb and owns the storage, pointers and handshake.

## Test plan
- XLEN=32, push 0xfff00093 (addi x1,x0,-1), out_ready=1
  → next cycle out_valid=1, opcode=00100, rd=1, rs1=0, rs2=0, imm=0xffffffff, sigill=0.
- DEPTH=4, out_ready=0, five consecutive pushes
  → in_ready=0 after the 4th accept, 5th held.
  - Raise out_ready → entries emerge in order one per cycle, and the 5th is accepted once count<4.
- Queue holding 3 entries, flush=1 together with in_valid=1
  → next cycle out_valid=0, count=0, and the flushed-cycle instruction never appears.
- XLEN=64, push 0x0010009b (addiw x1,x0,1) → opcode=00110, imm=1.
  - Push 0x80000537 (lui x10,0x80000) → imm=0xffffffff80000000.
  - Same addiw with XLEN=32 → sigill=1, other fields 0.
- Push 0x300110f3 (csrrw x1,0x300,x2):
  - with RV_DECODE_QUEUE_ZICSR_EN → funct3=001, rd=1, rs1=2, imm=0x300;
  - without the macro → sigill=1.
- Push 0x00000001 (compressed encoding) → sigill=1, out_pc preserved. Push 0x00000073 (ecall) → sigill=0, rd=rs1=rs2=0.
